nes_reader: RTL and testbench
=============================

# nes_reader

Self-contained NES controller serial reader that drives the controller latch/pulse lines, shifts in the 8 button bits, and publishes a clean active-high button word plus one-cycle new-press strobes once per poll period. It sits directly upstream of the pong datapath, one instance per controller port. It replaces the split control-unit/datapath NES handling with a single sequential block, and the datapath consumes `pressed` for paddle steps and Start/Select.

## Interface
- `LATCH_CYCLES`, 152: latch high time in clk cycles (6 µs at 25.175 MHz).
- `HALF_CYCLES`, 152: duration of each pulse-high phase and each pulse-low phase; must be ≥ 3.
- `POLL_CYCLES`, 419583: poll period (60 Hz); must exceed `LATCH_CYCLES + 15*HALF_CYCLES + 1`.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `nes_data`  in  1  controller serial data; asynchronous, active-low (0 = pressed).
- `nes_latch`  out  1  controller latch line.
- `nes_pulse`  out  1  controller clock line.
- `buttons`  out  8  held buttons, active-high: [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right.
- `pressed`  out  8  one-cycle strobe, bits newly pressed this frame.
- `frame_valid`  out  1  one-cycle strobe, `buttons`/`pressed` updated.

## Operation
- `nes_data` passes through a 2-flop synchronizer before any use; sampled value is inverted, so a released or disconnected line (pulled high) reads 0.
- Poll timer: free-running, counts 0..POLL_CYCLES-1, wraps to 0, and asserts an internal `start` on the wrap cycle. A `start` outside IDLE is ignored.
- States:
  - IDLE: latch=0, pulse=0. `start` → LATCH.
  - LATCH: latch=1 for LATCH_CYCLES → LOW with bit index 0.
  - LOW: pulse=0 for HALF_CYCLES. On the last cycle, sample the synchronized bit into the shift register at slot 7-index. If index=7 → DONE; otherwise → HIGH.
  - HIGH: pulse=1 for HALF_CYCLES, then index+1 → LOW.
  - DONE: one cycle. `buttons` ← shift value; `pressed` ← shift & ~old `buttons`; `frame_valid`=1; → IDLE.
- Phase timer: one down-counter, reloaded on every state entry, width clog2(max(LATCH_CYCLES, HALF_CYCLES)).
- `pressed` and `frame_valid` are 0 in every cycle except DONE.
- `buttons` holds its value between frames.

## Timing
- Reset values: state IDLE, poll counter 0, nes_latch 0, nes_pulse 0, buttons 8'h00, pressed 8'h00, frame_valid 0, shift register 0.
- After reset deasserts, the first `start` occurs when the poll count reaches POLL_CYCLES-1. Latch rises on the following cycle.
- Frame length, from latch rise to `frame_valid`: LATCH_CYCLES + 15*HALF_CYCLES + 1 cycles.
- Data capture latency: 2 sync flops, absorbed by HALF_CYCLES ≥ 3.
- Successive latch rises are exactly POLL_CYCLES cycles apart.
- Reset mid-frame: the frame is aborted, outputs return to reset values, and no partial word is ever published.
- A button held across frames: its `pressed` bit pulses only in the first frame it reads 1. After a release frame, a new press pulses again.
- All outputs are registered, with no combinational path from `nes_data`.

## Structure
- Package `nes_pkg`:
  - button index constants `BTN_A`..`BTN_RIGHT` (7..0);
  - state enum {IDLE, LATCH, LOW, HIGH, DONE};
  - default timing constants.
- One sub-module, `nes_poll_timer`: free-running modulo-POLL_CYCLES counter with a wrap strobe. Everything else stays inline in `nes_reader`.

## Test plan
Simulation parameters: L=4, H=4, POLL=100.

- Reset, then idle with nes_data=1 → first latch rise at cycle 100. Latch is high for exactly 4 cycles. Exactly 7 pulses of 4 cycles high / 4 low follow. frame_valid at cycle 100+65. buttons=00, pressed=00.
- Controller model drives A and Up pressed (bits 7, 3 low) → frame_valid with buttons=8'h88 and pressed=8'h88. Next frame with the same input gives buttons=8'h88, pressed=8'h00.
- Release Up, then press Down across three frames → pressed sequence 8'h04, 8'h00, …. buttons is 8'h80 while only A is held, and 8'h84 while A and Down are held.
- Assert reset during the HIGH phase of bit 4 → latch/pulse drop next cycle, buttons=00, no frame_valid. The next frame begins 100 cycles after reset release.
- Toggle nes_data every cycle outside sample points; hold it stable for 3 cycles before each LOW-phase end with pattern 8'b1010_0101 → buttons=8'h5A (inverted).
- Check the strobes over 5 frames: frame_valid is high for exactly 1 cycle per frame, and latch-rise spacing is always 100 cycles.

Source files
------------

// File: rtl/nes_pkg.sv
// nes_pkg: shared types and default timing for the NES controller reader.
// Button order matches the order the controller shifts its bits out.
package nes_pkg;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int DEF_LATCH_CYCLES = 152;
  localparam int DEF_HALF_CYCLES  = 152;
  localparam int DEF_POLL_CYCLES  = 419583;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } nes_state_e;

endpackage

// File: rtl/nes_poll_timer.sv
// nes_poll_timer: free-running modulo-POLL_CYCLES counter.
// wrap is high on the last count, one cycle per period.
module nes_poll_timer #(
  parameter int POLL_CYCLES = 419583
) (
  input  logic clk,
  input  logic reset,
  output logic wrap
);

  localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [CW-1:0] count;

  assign wrap = (count == CW'(POLL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/nes_reader.sv
// nes_reader: polls an NES controller once per period and publishes
// the held button word plus one-cycle new-press strobes.
module nes_reader
  import nes_pkg::*;
#(
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
  parameter int POLL_CYCLES  = DEF_POLL_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       frame_valid
);

  localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ?
                        LATCH_CYCLES : HALF_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] LATCH_LOAD = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_CYCLES - 1);

  nes_state_e    state;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [1:0]    sync_q;
  logic          start;
  logic          data_bit;

  nes_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_poll (
    .clk  (clk),
    .reset(reset),
    .wrap (start)
  );

  // Line idles high when released or unplugged, so invert to active-high.
  assign data_bit = ~sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], nes_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      idx         <= '0;
      shift       <= '0;
      nes_latch   <= 1'b0;
      nes_pulse   <= 1'b0;
      buttons     <= '0;
      pressed     <= '0;
      frame_valid <= 1'b0;
    end else begin
      pressed     <= '0;
      frame_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LATCH;
            nes_latch <= 1'b1;
            timer     <= LATCH_LOAD;
          end
        end
        LATCH: begin
          if (timer == '0) begin
            state     <= LOW;
            nes_latch <= 1'b0;
            idx       <= '0;
            timer     <= HALF_LOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        LOW: begin
          if (timer == '0) begin
            shift[3'd7 - idx] <= data_bit;
            if (idx == 3'd7) begin
              state <= DONE;
            end else begin
              state     <= HIGH;
              nes_pulse <= 1'b1;
              timer     <= HALF_LOAD;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        HIGH: begin
          if (timer == '0) begin
            state     <= LOW;
            nes_pulse <= 1'b0;
            idx       <= idx + 3'd1;
            timer     <= HALF_LOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE: begin
          buttons     <= shift;
          pressed     <= shift & ~buttons;
          frame_valid <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_reader.sv
// tb_nes_reader: frame-position model of the reader driven by a
// controller shift-register model and a glitchy-line pattern source.
module tb_nes_reader;

  localparam int L    = 4;
  localparam int H    = 4;
  localparam int POLL = 100;
  localparam int FV_POS = L + 15 * H + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       frame_valid;

  int total = 0;
  int bad   = 0;

  int   t       = 0;
  logic was_rst = 1'b0;

  logic [7:0] held = 8'h00;
  logic       mode = 1'b0;

  logic [7:0] mbtn;
  logic [7:0] last_pr = 8'h00;
  int         last_fv_t = -1;

  nes_reader #(
    .LATCH_CYCLES(L),
    .HALF_CYCLES (H),
    .POLL_CYCLES (POLL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .nes_data   (nes_data),
    .nes_latch  (nes_latch),
    .nes_pulse  (nes_pulse),
    .buttons    (buttons),
    .pressed    (pressed),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0d", name, act, exp, t);
    end
  endtask

  // Cycle index since the last reset edge.
  always @(posedge clk) begin
    was_rst <= reset;
    if (reset) t <= 0;
    else t <= t + 1;
  end

  // Line driver: real controller, or a line that toggles except
  // in the three cycles leading into each sample point.
  initial begin
    logic [7:0] creg;
    logic       prev_p;
    int         pos;
    logic       stable;
    logic       val;
    creg     = 8'hFF;
    prev_p   = 1'b0;
    nes_data = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!mode) begin
        if (nes_latch) creg = ~held;
        else if (nes_pulse && !prev_p) creg = {creg[6:0], 1'b1};
        nes_data = creg[7];
      end else begin
        stable = 1'b0;
        val    = 1'b1;
        if (t >= POLL) begin
          pos = (t - POLL) % POLL;
          for (int i = 0; i < 8; i++) begin
            int s;
            s = L + 2 * H * i + H - 1;
            if (pos >= s - 2 && pos <= s) begin
              stable = 1'b1;
              val    = ~held[7 - i];
            end
          end
        end
        nes_data = stable ? val : ~nes_data;
      end
      prev_p = nes_pulse;
    end
  end

  // Model and compare, every cycle.
  initial begin
    int   pos;
    int   rel;
    logic in_frame;
    logic exp_l;
    logic exp_p;
    logic exp_fv;
    logic [7:0] exp_pr;
    logic prev_latch;
    int   last_rise;
    int   fvcnt;
    mbtn       = 8'h00;
    prev_latch = 1'b0;
    last_rise  = -1;
    fvcnt      = 0;
    forever begin
      @(negedge clk);
      if (was_rst) begin
        mbtn      = 8'h00;
        last_rise = -1;
        fvcnt     = 0;
      end
      in_frame = (t >= POLL) && !was_rst;
      pos      = in_frame ? (t - POLL) % POLL : -1;
      rel      = pos - L;
      exp_l    = in_frame && pos < L;
      exp_p    = in_frame && rel >= 0 && rel < 15 * H &&
                 ((rel / H) % 2 == 1);
      exp_fv   = in_frame && pos == FV_POS;
      exp_pr   = 8'h00;
      if (exp_fv) begin
        exp_pr = held & ~mbtn;
        mbtn   = held;
      end
      chk("latch", 32'(nes_latch), 32'(exp_l));
      chk("pulse", 32'(nes_pulse), 32'(exp_p));
      chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
      chk("pressed", 32'(pressed), 32'(exp_pr));
      chk("buttons", 32'(buttons), 32'(mbtn));
      if (nes_latch && !prev_latch) begin
        if (last_rise >= 0) begin
          chk("latch_gap", 32'(t - last_rise), 32'd100);
          chk("fv_per_frame", 32'(fvcnt), 32'd1);
        end else begin
          chk("first_rise", 32'(t), 32'd100);
        end
        last_rise = t;
        fvcnt     = 0;
      end
      if (frame_valid) begin
        fvcnt++;
        last_pr   = pressed;
        last_fv_t = t;
      end
      prev_latch = nes_latch;
    end
  end

  task automatic wait_pos(input int p);
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      if (t >= POLL && (t - POLL) % POLL == p) return;
    end
    chk("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wait_pos(80);
    chk("lit_fv_t", 32'(last_fv_t), 32'd165);
    chk("lit_btn_idle", 32'(buttons), 32'h00);
    chk("lit_pr_idle", 32'(last_pr), 32'h00);

    held = 8'h88;
    wait_pos(80);
    chk("lit_btn_a_up", 32'(buttons), 32'h88);
    chk("lit_pr_a_up", 32'(last_pr), 32'h88);
    wait_pos(80);
    chk("lit_pr_held", 32'(last_pr), 32'h00);

    held = 8'h80;
    wait_pos(80);
    chk("lit_btn_a", 32'(buttons), 32'h80);
    held = 8'h84;
    wait_pos(80);
    chk("lit_pr_down", 32'(last_pr), 32'h04);
    chk("lit_btn_a_down", 32'(buttons), 32'h84);
    wait_pos(80);
    chk("lit_pr_down2", 32'(last_pr), 32'h00);

    wait_pos(41);
    reset = 1'b1;
    @(negedge clk);
    chk("lit_rst_latch", 32'(nes_latch), 32'd0);
    chk("lit_rst_pulse", 32'(nes_pulse), 32'd0);
    chk("lit_rst_btn", 32'(buttons), 32'h00);
    reset = 1'b0;

    wait_pos(80);
    chk("lit_btn_after_rst", 32'(buttons), 32'h84);
    chk("lit_pr_after_rst", 32'(last_pr), 32'h84);

    held = 8'h5A;
    mode = 1'b1;
    wait_pos(80);
    chk("lit_btn_glitchy", 32'(buttons), 32'h5A);

    repeat (5) wait_pos(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
